noc_async_fifo_wr_side: RTL and testbench
=========================================

# noc_async_fifo_wr_side

Write-side endpoint of the NoC dual-clock FIFO link, i.e. the producer end of the `noc_fifo_*_data / raddr / waddr` triple used by every unit domain. It accepts packets on a valid/ready stream and stores them in a local register-file ring. It publishes a Gray-coded write pointer and serves read data indexed by the remote reader's Gray-coded read pointer. It synchronizes that read pointer locally to derive full/level. Two instances per domain close the link: one on the NoC side feeding a unit's `*_in_*` ports, one in the unit feeding the NoC via `*_out_*`.

## Interface
- `PACKET_SIZE`, default 128: packet width in bits; equals `NOC_ASYNC_FIFO_PACKET_SIZE` at integration.
- `AWIDTH`, default 3: address width; `DEPTH = 2**AWIDTH` entries; equals `NOC_ASYNC_FIFO_AWIDTH`.
- `clk_i`  in  1  write-domain clock; the only clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `wr_valid_i`  in  1  packet offered.
- `wr_data_i`  in  PACKET_SIZE  packet payload.
- `wr_ready_o`  out  1  FIFO not full; transfer when `wr_valid_i & wr_ready_o` at a rising edge.
- `fifo_data_o`  out  PACKET_SIZE  entry addressed by `fifo_raddr_i`, toward the remote reader.
- `fifo_raddr_i`  in  AWIDTH+1  remote Gray read pointer, asynchronous to `clk_i`.
- `fifo_waddr_o`  out  AWIDTH+1  local Gray write pointer, registered.
- `fill_level_o`  out  AWIDTH+1  occupancy as seen locally, 0..DEPTH.

## Operation
- State: `wbin_q` (AWIDTH+1 binary write pointer), `wgray_q` (AWIDTH+1 Gray), `rsync1_q`/`rsync2_q` (2-flop synchronizer on `fifo_raddr_i`), `mem[DEPTH]` (no reset).
- Accept: on an edge with `wr_valid_i & wr_ready_o`, `mem[wbin_q[AWIDTH-1:0]] <= wr_data_i`, `wbin_q <= wbin_q+1` (mod 2**(AWIDTH+1)), `wgray_q <= bin2gray(wbin_q+1)`. Memory write and pointer publish share the same edge; the reader's own 2-flop sync guarantees data stability before use.
- `fifo_waddr_o = wgray_q`; only registered bits drive it, so exactly one bit toggles per accept.
- `rbin = gray2bin(rsync2_q)`; `fill_level_o = wbin_q - rbin` (AWIDTH+1 bit modular subtraction).
- Full: `wgray_q == {~rsync2_q[AWIDTH:AWIDTH-1], rsync2_q[AWIDTH-2:0]}` (for AWIDTH=1: `{~rsync2_q[1:0]}`). `wr_ready_o = ~full`. Both are combinational from registers only.
- `fifo_data_o = mem[gray2bin(fifo_raddr_i)[AWIDTH-1:0]]`, a combinational read from the raw input. It is not synchronized, by design, because the reader only consumes entries whose write it has already observed.
- `wr_valid_i` without `wr_ready_o` holds nothing; the producer must keep data stable (standard valid/ready). `wr_valid_i` may drop without a transfer.

## Timing
- Reset (async assert, sync use after deassert): `wbin_q = wgray_q = 0`, `rsync* = 0` → `fifo_waddr_o = 0`, `fill_level_o = 0`, `wr_ready_o = 1`. `fifo_data_o` is X until entries are written. No write occurs while `reset_n_i` is low.
- Write latency: an accept at edge k → `fifo_waddr_o` and `fill_level_o` updated after edge k.
- Read-pointer latency: a `fifo_raddr_i` change settled before edge k → captured in `rsync1_q` at k, `rsync2_q` at k+1. `fill_level_o`/`wr_ready_o` reflect it after edge k+1. Full is therefore conservative; it never overflows.
- Full boundary: after the DEPTH-th unconsumed accept, `wr_ready_o` is 0 in the next cycle. A back-to-back valid is not accepted.
- Simultaneous accept and read-pointer advance at the same edge: both apply; level net unchanged.
- Wrap: pointers wrap at 2**(AWIDTH+1). The MSB distinguishes full (level DEPTH) from empty (level 0).
- Reset mid-operation: pointers return to 0 immediately, stored packets are discarded, and `wr_ready_o = 1`. The remote side must be reset concurrently.

## Test plan
- AWIDTH=3, reader frozen at `fifo_raddr_i=0`, 8 back-to-back writes 0x1..0x8 → `wr_ready_o` low after the 8th edge, `fill_level_o=8`, `fifo_waddr_o=4'b1100`. A 9th valid is held and not accepted.
- From full, set `fifo_raddr_i=4'b0001` → `wr_ready_o` high exactly 2 edges later, `fill_level_o=7`; `fifo_data_o` shows 0x2.
- 40 packets with a reader model stepping `fifo_raddr_i` in Gray at an unrelated rate → all 40 are read in order with no loss or duplication. Every `fifo_waddr_o` transition differs in exactly one bit, including wrap from 4'b1000 to 4'b0000.
- At level 7, accept a write on the same edge as the synchronized read increment → level stays 7, `wr_ready_o` stays 1.
- Assert `reset_n_i` low asynchronously mid-burst at level 5 → outputs go to 0/0/1 without a clock edge. After release, the first write lands at index 0 and `fifo_waddr_o=4'b0001`.

Source files
------------

// File: rtl/noc_async_fifo_wr_side.sv
// Producer end of the NoC dual-clock FIFO link.
// Holds packets in a local register-file ring and publishes a Gray write pointer.
// The remote reader indexes the ring with its own Gray read pointer.
// That read pointer is synchronized locally to derive full and fill level.
module noc_async_fifo_wr_side #(
  parameter int PACKET_SIZE = 128,
  parameter int AWIDTH      = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   wr_valid_i,
  input  logic [PACKET_SIZE-1:0] wr_data_i,
  output logic                   wr_ready_o,
  output logic [PACKET_SIZE-1:0] fifo_data_o,
  input  logic [AWIDTH:0]        fifo_raddr_i,
  output logic [AWIDTH:0]        fifo_waddr_o,
  output logic [AWIDTH:0]        fill_level_o
);

  localparam int DEPTH = 2 ** AWIDTH;
  // Inverting the top two Gray bits of the read pointer gives the write
  // pointer value that sits exactly DEPTH entries ahead (full).
  localparam int unsigned    FULL_MASK_INT = 32'd3 << (AWIDTH - 1);
  localparam logic [AWIDTH:0] FULL_MASK    = FULL_MASK_INT[AWIDTH:0];
  localparam logic [AWIDTH:0] PTR_ONE      = (AWIDTH + 1)'(1);

  function automatic logic [AWIDTH:0] bin2gray(input logic [AWIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
    logic [AWIDTH:0] b;
    b[AWIDTH] = g[AWIDTH];
    for (int i = AWIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AWIDTH:0]        wbin_q, wbin_d;
  logic [AWIDTH:0]        wgray_q, wgray_d;
  logic [AWIDTH:0]        rsync1_q, rsync1_d;
  logic [AWIDTH:0]        rsync2_q, rsync2_d;
  logic [PACKET_SIZE-1:0] mem [DEPTH];

  logic                   full;
  logic                   accept;
  logic                   mem_we;
  logic [AWIDTH:0]        rbin;
  logic [AWIDTH-1:0]      rd_idx;
  logic                   rd_acc;

  // Full/ready/level are derived from registered state only.
  always_comb begin
    full         = (wgray_q == (rsync2_q ^ FULL_MASK));
    wr_ready_o   = ~full;
    rbin         = gray2bin(rsync2_q);
    fill_level_o = wbin_q - rbin;
    fifo_waddr_o = wgray_q;
  end

  // Next-state: advance the write pointer on a transfer, shift the synchronizer.
  always_comb begin
    accept   = wr_valid_i & wr_ready_o;
    mem_we   = accept & reset_n_i;
    wbin_d   = wbin_q;
    wgray_d  = wgray_q;
    if (accept) begin
      wbin_d  = wbin_q + PTR_ONE;
      wgray_d = bin2gray(wbin_q + PTR_ONE);
    end
    rsync1_d = fifo_raddr_i;
    rsync2_d = rsync1_q;
  end

  // Pointer and synchronizer registers; reset returns the link to empty.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rsync1_q <= rsync1_d;
      rsync2_q <= rsync2_d;
    end
  end

  // Ring storage; no reset, written on the same edge the pointer is published.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wbin_q[AWIDTH-1:0]] <= wr_data_i;
    end
  end

  // Remote read index from the raw Gray pointer; the reader only addresses
  // entries whose write it has already observed, so no synchronization here.
  always_comb begin
    rd_acc = fifo_raddr_i[AWIDTH];
    rd_idx = '0;
    for (int i = AWIDTH - 1; i >= 0; i--) begin
      rd_acc    = rd_acc ^ fifo_raddr_i[i];
      rd_idx[i] = rd_acc;
    end
    fifo_data_o = mem[rd_idx];
  end

endmodule

// File: tb/tb_noc_async_fifo_wr_side.sv
// Bench for the FIFO write-side endpoint: directed corner cases followed by a
// randomized producer/reader run against a count-based reference model.
module tb_noc_async_fifo_wr_side;
  localparam int PW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          wr_valid_i = 1'b0;
  logic [PW-1:0] wr_data_i = '0;
  logic          wr_ready_o;
  logic [PW-1:0] fifo_data_o;
  logic [AW:0]   fifo_raddr_i = '0;
  logic [AW:0]   fifo_waddr_o;
  logic [AW:0]   fill_level_o;

  noc_async_fifo_wr_side #(.PACKET_SIZE(PW), .AWIDTH(AW)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .wr_valid_i(wr_valid_i),
    .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o),
    .fifo_data_o(fifo_data_o),
    .fifo_raddr_i(fifo_raddr_i),
    .fifo_waddr_o(fifo_waddr_o),
    .fill_level_o(fill_level_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: absolute packet counts. Writer count, reader count, and
  // the reader count as seen through two clock edges of synchronization.
  int            checks = 0;
  int            passes = 0;
  int            wcount = 0;
  int            rcount = 0;
  int            s1 = 0;
  int            s2 = 0;
  bit            last_acc = 1'b0;
  logic [AW:0]   prev_waddr = '0;
  logic [PW-1:0] pkts[$];

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    check("waddr", PW'(fifo_waddr_o), PW'(gray_of(wcount)));
    check("level", PW'(fill_level_o), PW'(wcount - s2));
    check("ready", PW'(wr_ready_o), PW'((wcount - s2) < DEPTH));
  endtask

  // One clock: decide acceptance from pre-edge model state, advance, check.
  task automatic step();
    bit acc;
    acc = wr_valid_i && ((wcount - s2) < DEPTH);
    @(posedge clk_i);
    if (acc) begin
      pkts.push_back(wr_data_i);
      wcount++;
    end
    s2 = s1;
    s1 = rcount;
    last_acc = acc;
    #1;
    check_outputs();
    if (fifo_waddr_o !== prev_waddr)
      check("gray_1bit", PW'($countones(fifo_waddr_o ^ prev_waddr)), PW'(1));
    prev_waddr = fifo_waddr_o;
  endtask

  // Asynchronous reset between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    #2;
    reset_n_i    = 1'b0;
    wr_valid_i   = 1'b0;
    fifo_raddr_i = '0;
    wcount = 0; rcount = 0; s1 = 0; s2 = 0;
    pkts.delete();
    #1;
    check("rst_waddr", PW'(fifo_waddr_o), PW'(0));
    check("rst_level", PW'(fill_level_o), PW'(0));
    check("rst_ready", PW'(wr_ready_o), PW'(1));
    prev_waddr = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    int target;
    #1;
    do_reset();

    // Fill with the reader frozen at 0.
    for (int i = 1; i <= DEPTH; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = PW'(i);
      step();
    end
    check("full_ready", PW'(wr_ready_o), PW'(0));
    check("full_level", PW'(fill_level_o), PW'(8));
    check("full_waddr", PW'(fifo_waddr_o), PW'(4'b1100));

    // A ninth offer is held, not accepted.
    wr_data_i = PW'(9);
    step();
    check("held_level", PW'(fill_level_o), PW'(8));
    wr_valid_i = 1'b0;

    // Reader consumes one entry: ready returns exactly two edges later.
    rcount = 1;
    fifo_raddr_i = gray_of(rcount);
    step();
    check("ready_lag1", PW'(wr_ready_o), PW'(0));
    step();
    check("ready_lag2", PW'(wr_ready_o), PW'(1));
    check("level_7", PW'(fill_level_o), PW'(7));
    check("rdata_0x2", fifo_data_o, PW'(2));
    check("rdata_model", fifo_data_o, pkts[rcount]);

    // Write on the same edge the synchronized read pointer advances.
    rcount = 2;
    fifo_raddr_i = gray_of(rcount);
    step();
    wr_valid_i = 1'b1;
    wr_data_i  = PW'(32'h0000_0010);
    step();
    wr_valid_i = 1'b0;
    check("simul_level", PW'(fill_level_o), PW'(7));
    check("simul_ready", PW'(wr_ready_o), PW'(1));

    // Mid-burst asynchronous reset at level 5.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = $urandom;
      step();
    end
    check("pre_rst_level", PW'(fill_level_o), PW'(5));
    do_reset();
    wr_valid_i = 1'b1;
    wr_data_i  = 32'hA5A5_0001;
    step();
    wr_valid_i = 1'b0;
    check("post_rst_waddr", PW'(fifo_waddr_o), PW'(4'b0001));
    check("post_rst_data", fifo_data_o, PW'(32'hA5A5_0001));

    // Randomized producer and reader at unrelated rates.
    target = wcount + 40;
    for (int cyc = 0; cyc < 3000 && rcount < target; cyc++) begin
      if (!wr_valid_i && wcount < target && $urandom_range(3) != 0) begin
        wr_valid_i = 1'b1;
        wr_data_i  = $urandom;
      end
      step();
      if (last_acc) wr_valid_i = 1'b0;
      if (rcount < wcount && $urandom_range(2) == 0) begin
        check("rand_rdata", fifo_data_o, pkts[rcount]);
        rcount++;
        fifo_raddr_i = gray_of(rcount);
      end
    end
    check("rand_all_written", PW'(wcount), PW'(target));
    check("rand_all_read", PW'(rcount), PW'(target));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
